// File: rtl/tower_pkg.sv
// Shared types and the tower cost table for the build controller.
package tower_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_RELEASE,
    ST_REJECT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    RESP_OK       = 2'd0,
    RESP_SLOT     = 2'd1,
    RESP_BAD_TYPE = 2'd2,
    RESP_NO_GOLD  = 2'd3
  } resp_code_t;

  localparam int unsigned COST_W = 10;

  // Build cost per tower type; 0 marks an invalid type.
  localparam logic [COST_W-1:0] TOWER_COST [8] = '{
    10'd0, 10'd100, 10'd120, 10'd160, 10'd220, 10'd0, 10'd0, 10'd0
  };

  function automatic logic [COST_W-1:0] tower_cost(input logic [2:0] tower_type);
    return TOWER_COST[tower_type];
  endfunction

endpackage

// File: rtl/tower_build_ctrl_gold_ledger.sv
// Saturating gold accumulator: credit (kill rewards), refund (sell) and debit (build).
module gold_ledger
  import tower_pkg::*;
#(
  parameter int unsigned GOLD_W    = 12,
  parameter int unsigned GOLD_INIT = 200,
  parameter int unsigned GOLD_MAX  = 4095
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        credit,
  input  logic [COST_W-1:0] refund,
  input  logic [COST_W-1:0] debit,
  output logic [GOLD_W-1:0] gold
);

  localparam int unsigned SUM_W = GOLD_W + 2;

  logic [GOLD_W-1:0] gold_q;
  logic [GOLD_W-1:0] gold_d;
  logic [SUM_W-1:0]  sum;

  // Next balance: two guard bits keep the sum exact before clamping to the ceiling.
  always_comb begin
    sum = SUM_W'(gold_q) + SUM_W'(credit) + SUM_W'(refund) - SUM_W'(debit);
    if (sum > SUM_W'(GOLD_MAX)) begin
      gold_d = GOLD_W'(GOLD_MAX);
    end else begin
      gold_d = sum[GOLD_W-1:0];
    end
  end

  // Balance register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gold_q <= GOLD_W'(GOLD_INIT);
    end else begin
      gold_q <= gold_d;
    end
  end

  assign gold = gold_q;

endmodule

// File: rtl/tower_build_ctrl.sv
// Build/sell command sequencer: validates one request at a time, drives the tower
// array strobe, and keeps slot occupancy and the gold balance.
module tower_build_ctrl
  import tower_pkg::*;
#(
  parameter int unsigned GOLD_W    = 12,
  parameter int unsigned GOLD_INIT = 200,
  parameter int unsigned GOLD_MAX  = 4095
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_sell,
  input  logic [2:0]        req_loc,
  input  logic [2:0]        req_type,
  input  logic              reward_valid,
  input  logic [7:0]        reward_amt,
  output logic              command_tw,
  output logic              build,
  output logic              sell,
  output logic [2:0]        build_location,
  output logic [2:0]        build_type,
  output logic [7:0]        occupied,
  output logic [GOLD_W-1:0] gold,
  output logic              resp_valid,
  output logic              resp_ok,
  output logic [1:0]        resp_code
);

  ctrl_state_t state_q, state_d;

  logic       sell_lq, sell_ld;
  logic [2:0] loc_lq, loc_ld;
  logic [2:0] type_lq, type_ld;

  logic [7:0] occupied_q, occupied_d;
  logic [2:0] slot_type_q [8];
  logic [2:0] slot_type_d [8];

  logic       command_tw_q, command_tw_d;
  logic       build_q, build_d;
  logic       sell_q, sell_d;
  logic [2:0] build_location_q, build_location_d;
  logic [2:0] build_type_q, build_type_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_ok_q, resp_ok_d;
  resp_code_t resp_code_q, resp_code_d;

  logic              chk_pass;
  resp_code_t        chk_code;
  logic [COST_W-1:0] debit;
  logic [COST_W-1:0] refund;
  logic [7:0]        credit;

  assign credit = reward_valid ? reward_amt : '0;

  gold_ledger #(
    .GOLD_W   (GOLD_W),
    .GOLD_INIT(GOLD_INIT),
    .GOLD_MAX (GOLD_MAX)
  ) u_gold_ledger (
    .Clk   (Clk),
    .Reset (Reset),
    .credit(credit),
    .refund(refund),
    .debit (debit),
    .gold  (gold)
  );

  // Validate the latched request against type, occupancy and balance, in priority order.
  always_comb begin
    chk_code = RESP_OK;
    if (sell_lq) begin
      if (!occupied_q[loc_lq]) chk_code = RESP_SLOT;
    end else if (type_lq < 3'd1 || type_lq > 3'd4) begin
      chk_code = RESP_BAD_TYPE;
    end else if (occupied_q[loc_lq]) begin
      chk_code = RESP_SLOT;
    end else if ((GOLD_W + 2)'(gold) < (GOLD_W + 2)'(tower_cost(type_lq))) begin
      chk_code = RESP_NO_GOLD;
    end
    chk_pass = (chk_code == RESP_OK);
  end

  // Next state, slot record and ledger deltas; output flops load from the state being entered.
  always_comb begin
    state_d          = state_q;
    sell_ld          = sell_lq;
    loc_ld           = loc_lq;
    type_ld          = type_lq;
    occupied_d       = occupied_q;
    slot_type_d      = slot_type_q;
    command_tw_d     = 1'b0;
    build_d          = 1'b0;
    sell_d           = 1'b0;
    build_location_d = build_location_q;
    build_type_d     = build_type_q;
    resp_valid_d     = 1'b0;
    resp_ok_d        = 1'b0;
    resp_code_d      = resp_code_q;
    debit            = '0;
    refund           = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sell_ld = req_sell;
          loc_ld  = req_loc;
          type_ld = req_type;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_pass) begin
          state_d          = ST_ISSUE;
          command_tw_d     = 1'b1;
          build_d          = !sell_lq;
          sell_d           = sell_lq;
          build_location_d = loc_lq;
          build_type_d     = sell_lq ? slot_type_q[loc_lq] : type_lq;
        end else begin
          state_d      = ST_REJECT;
          resp_valid_d = 1'b1;
          resp_code_d  = chk_code;
        end
      end
      ST_ISSUE: begin
        if (sell_lq) begin
          refund                 = tower_cost(slot_type_q[loc_lq]) >> 1;
          occupied_d[loc_lq]     = 1'b0;
          slot_type_d[loc_lq]    = '0;
        end else begin
          debit                  = tower_cost(type_lq);
          occupied_d[loc_lq]     = 1'b1;
          slot_type_d[loc_lq]    = type_lq;
        end
        state_d      = ST_RELEASE;
        resp_valid_d = 1'b1;
        resp_ok_d    = 1'b1;
        resp_code_d  = RESP_OK;
      end
      ST_RELEASE: state_d = ST_IDLE;
      ST_REJECT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, request latch, slot record and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q          <= ST_IDLE;
      sell_lq          <= 1'b0;
      loc_lq           <= '0;
      type_lq          <= '0;
      occupied_q       <= '0;
      slot_type_q      <= '{default: '0};
      command_tw_q     <= 1'b0;
      build_q          <= 1'b0;
      sell_q           <= 1'b0;
      build_location_q <= '0;
      build_type_q     <= '0;
      resp_valid_q     <= 1'b0;
      resp_ok_q        <= 1'b0;
      resp_code_q      <= RESP_OK;
    end else begin
      state_q          <= state_d;
      sell_lq          <= sell_ld;
      loc_lq           <= loc_ld;
      type_lq          <= type_ld;
      occupied_q       <= occupied_d;
      slot_type_q      <= slot_type_d;
      command_tw_q     <= command_tw_d;
      build_q          <= build_d;
      sell_q           <= sell_d;
      build_location_q <= build_location_d;
      build_type_q     <= build_type_d;
      resp_valid_q     <= resp_valid_d;
      resp_ok_q        <= resp_ok_d;
      resp_code_q      <= resp_code_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign command_tw     = command_tw_q;
  assign build          = build_q;
  assign sell           = sell_q;
  assign build_location = build_location_q;
  assign build_type     = build_type_q;
  assign occupied       = occupied_q;
  assign resp_valid     = resp_valid_q;
  assign resp_ok        = resp_ok_q;
  assign resp_code      = resp_code_q;

endmodule
